usb_pulpino_mailbox: RTL and testbench

Parametrised bidirectional mailbox between the USB register front-end and the PULPino GPIO port. It replaces the single-register channel with two independent FIFOs, USB->PULPino (U2P) and PULPino->USB (P2U), each pDEPTH deep and pDATA_WIDTH wide. Pushes and pops are signalled by toggling "flicker" lines: every change of level is one event. Both sides run on the PULPino clock; the USB register block already presents its outputs in that domain.

---
 rtl/usb_pulpino_pkg.sv | 13 +
 rtl/mbox_fifo.sv | 103 ++++++++++
 rtl/usb_pulpino_mailbox.sv | 102 ++++++++++
 tb/tb_usb_pulpino_mailbox.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pulpino_pkg.sv
// Shared constants for the USB <-> PULPino mailbox: default geometry and
// status-word bit positions (given as offsets above the occupancy count field).
package usb_pulpino_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 4;

    // Status word = {overflow, underflow, count}; flag bits sit at pCNT_WIDTH + offset.
    localparam int STAT_CNT_LSB       = 0;
    localparam int STAT_UNDERFLOW_BIT = 0;
    localparam int STAT_OVERFLOW_BIT  = 1;

endpackage

// File: rtl/mbox_fifo.sv
// One mailbox direction: flicker-driven push/pop FIFO with sticky over/underflow
// flags, flush, and a combinational head output masked to zero when empty.
module mbox_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  push_flicker,
    input  logic                  pop_flicker,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  push_done
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_reg;
    logic [PTR_WIDTH-1:0]  rd_ptr_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  push_hist_reg;
    logic                  pop_hist_reg;

    logic push_ev;
    logic pop_ev;
    logic is_full;
    logic is_empty;
    logic do_push;
    logic do_pop;

    assign push_ev  = push_flicker ^ push_hist_reg;
    assign pop_ev   = pop_flicker ^ pop_hist_reg;
    assign is_full  = (count_reg == FULL_COUNT);
    assign is_empty = (count_reg == '0);

    // A pop on a full FIFO frees the slot the concurrent push needs; an empty FIFO never bypasses.
    assign do_pop  = pop_ev && !is_empty;
    assign do_push = push_ev && (!is_full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            push_hist_reg <= 1'b0;
            pop_hist_reg  <= 1'b0;
        end else begin
            // History always follows the inputs so flushed events are never replayed.
            push_hist_reg <= push_flicker;
            pop_hist_reg  <= pop_flicker;
            if (flush) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                count_reg     <= '0;
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (do_push && !do_pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (!do_push && do_pop) begin
                    count_reg <= count_reg - 1'b1;
                end
                if (push_ev && !do_push) begin
                    overflow_reg <= 1'b1;
                end
                if (pop_ev && !do_pop) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left unreset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    assign rdata     = is_empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign push_done = do_push && !flush;

endmodule

// File: rtl/usb_pulpino_mailbox.sv
// Bidirectional USB <-> PULPino mailbox built from two independent flicker FIFOs.
// Optional macro USB_PULPINO_MAILBOX_IRQ_EN adds pulp_irq, one pulse per accepted USB push.
module usb_pulpino_mailbox
    import usb_pulpino_pkg::*;
#(
    parameter int pDATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int pDEPTH      = DEFAULT_DEPTH,
    parameter int pCNT_WIDTH  = $clog2(pDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic [pDATA_WIDTH-1:0] usb_wdata,
    input  logic                   usb_write_flicker,
    input  logic                   usb_read_flicker,
    output logic [pDATA_WIDTH-1:0] usb_rdata,
    output logic [pCNT_WIDTH+1:0]  usb_status,
    input  logic [pDATA_WIDTH-1:0] pulp_wdata,
    input  logic                   pulp_write_flicker,
    input  logic                   pulp_read_flicker,
    output logic [pDATA_WIDTH-1:0] pulp_rdata,
    output logic [pCNT_WIDTH+1:0]  pulp_status
`ifdef USB_PULPINO_MAILBOX_IRQ_EN
    ,
    output logic                   pulp_irq
`endif
);

    logic [pCNT_WIDTH-1:0] u2p_count;
    logic [pCNT_WIDTH-1:0] p2u_count;
    logic u2p_overflow;
    logic u2p_underflow;
    logic p2u_overflow;
    logic p2u_underflow;
    logic u2p_push_done;
    logic p2u_push_done;

    mbox_fifo #(
        .DATA_WIDTH(pDATA_WIDTH),
        .DEPTH     (pDEPTH),
        .CNT_WIDTH (pCNT_WIDTH)
    ) u_u2p (
        .clk         (clk),
        .rst         (reset_i),
        .flush       (flush_i),
        .wdata       (usb_wdata),
        .push_flicker(usb_write_flicker),
        .pop_flicker (pulp_read_flicker),
        .rdata       (pulp_rdata),
        .count       (u2p_count),
        .overflow    (u2p_overflow),
        .underflow   (u2p_underflow),
        .push_done   (u2p_push_done)
    );

    mbox_fifo #(
        .DATA_WIDTH(pDATA_WIDTH),
        .DEPTH     (pDEPTH),
        .CNT_WIDTH (pCNT_WIDTH)
    ) u_p2u (
        .clk         (clk),
        .rst         (reset_i),
        .flush       (flush_i),
        .wdata       (pulp_wdata),
        .push_flicker(pulp_write_flicker),
        .pop_flicker (usb_read_flicker),
        .rdata       (usb_rdata),
        .count       (p2u_count),
        .overflow    (p2u_overflow),
        .underflow   (p2u_underflow),
        .push_done   (p2u_push_done)
    );

    // Each side sees its own inbound count but the peer's underflow, so both misuse cases are visible.
    assign usb_status[STAT_CNT_LSB +: pCNT_WIDTH]           = p2u_count;
    assign usb_status[pCNT_WIDTH + STAT_UNDERFLOW_BIT]      = u2p_underflow;
    assign usb_status[pCNT_WIDTH + STAT_OVERFLOW_BIT]       = p2u_overflow;
    assign pulp_status[STAT_CNT_LSB +: pCNT_WIDTH]          = u2p_count;
    assign pulp_status[pCNT_WIDTH + STAT_UNDERFLOW_BIT]     = p2u_underflow;
    assign pulp_status[pCNT_WIDTH + STAT_OVERFLOW_BIT]      = u2p_overflow;

`ifdef USB_PULPINO_MAILBOX_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= u2p_push_done;
        end
    end

    assign pulp_irq = irq_reg;

    logic unused_push_done;
    assign unused_push_done = p2u_push_done;
`else
    logic unused_push_done;
    assign unused_push_done = u2p_push_done ^ p2u_push_done;
`endif

endmodule

// File: tb/tb_usb_pulpino_mailbox.sv
// Bench for usb_pulpino_mailbox: queue-based model checked every cycle, directed
// scenarios with literal expectations, then randomized flicker traffic.
module tb_usb_pulpino_mailbox;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);
    localparam int SW = CW + 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic [W-1:0]  usb_wdata;
    logic          usb_write_flicker;
    logic          usb_read_flicker;
    logic [W-1:0]  usb_rdata;
    logic [SW-1:0] usb_status;
    logic [W-1:0]  pulp_wdata;
    logic          pulp_write_flicker;
    logic          pulp_read_flicker;
    logic [W-1:0]  pulp_rdata;
    logic [SW-1:0] pulp_status;
`ifdef USB_PULPINO_MAILBOX_IRQ_EN
    logic          pulp_irq;
`endif

    usb_pulpino_mailbox #(
        .pDATA_WIDTH(W),
        .pDEPTH     (D)
    ) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .flush_i           (flush_i),
        .usb_wdata         (usb_wdata),
        .usb_write_flicker (usb_write_flicker),
        .usb_read_flicker  (usb_read_flicker),
        .usb_rdata         (usb_rdata),
        .usb_status        (usb_status),
        .pulp_wdata        (pulp_wdata),
        .pulp_write_flicker(pulp_write_flicker),
        .pulp_read_flicker (pulp_read_flicker),
        .pulp_rdata        (pulp_rdata),
        .pulp_status       (pulp_status)
`ifdef USB_PULPINO_MAILBOX_IRQ_EN
        ,
        .pulp_irq          (pulp_irq)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: one queue per direction plus sticky flags.
    logic [W-1:0] u2p_q[$];
    logic [W-1:0] p2u_q[$];
    bit u2p_ovf, u2p_unf, p2u_ovf, p2u_unf;
    bit irq_exp;
    bit prev_uw, prev_ur, prev_pw, prev_pr;
    bit chk_en;
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of events to the model.
    task automatic model_edge();
        bit ev_uw, ev_ur, ev_pw, ev_pr;
        ev_uw = usb_write_flicker ^ prev_uw;
        ev_ur = usb_read_flicker ^ prev_ur;
        ev_pw = pulp_write_flicker ^ prev_pw;
        ev_pr = pulp_read_flicker ^ prev_pr;
        prev_uw = usb_write_flicker;
        prev_ur = usb_read_flicker;
        prev_pw = pulp_write_flicker;
        prev_pr = pulp_read_flicker;
        irq_exp = 1'b0;
        if (flush_i) begin
            u2p_q.delete();
            p2u_q.delete();
            u2p_ovf = 0; u2p_unf = 0; p2u_ovf = 0; p2u_unf = 0;
        end else begin
            if (ev_pr) begin
                if (u2p_q.size() == 0) u2p_unf = 1;
                else void'(u2p_q.pop_front());
            end
            if (ev_uw) begin
                if (u2p_q.size() < D) begin
                    u2p_q.push_back(usb_wdata);
                    irq_exp = 1'b1;
                end else u2p_ovf = 1;
            end
            if (ev_ur) begin
                if (p2u_q.size() == 0) p2u_unf = 1;
                else void'(p2u_q.pop_front());
            end
            if (ev_pw) begin
                if (p2u_q.size() < D) p2u_q.push_back(pulp_wdata);
                else p2u_ovf = 1;
            end
        end
    endtask

    task automatic step(input bit tuw, input bit tur, input bit tpw, input bit tpr,
                        input logic [W-1:0] ud, input logic [W-1:0] pd, input bit fl);
        @(negedge clk);
        usb_wdata  = ud;
        pulp_wdata = pd;
        flush_i    = fl;
        if (tuw) usb_write_flicker  = ~usb_write_flicker;
        if (tur) usb_read_flicker   = ~usb_read_flicker;
        if (tpw) pulp_write_flicker = ~pulp_write_flicker;
        if (tpr) pulp_read_flicker  = ~pulp_read_flicker;
        @(posedge clk);
        model_edge();
    endtask

    task automatic do_flush();
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
    endtask

    // Compare process: outputs are register-driven, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pulp_rdata", pulp_rdata, (u2p_q.size() != 0) ? u2p_q[0] : '0);
            check("usb_rdata", usb_rdata, (p2u_q.size() != 0) ? p2u_q[0] : '0);
            check("pulp_status", pulp_status, {u2p_ovf, p2u_unf, CW'(u2p_q.size())});
            check("usb_status", usb_status, {p2u_ovf, u2p_unf, CW'(p2u_q.size())});
`ifdef USB_PULPINO_MAILBOX_IRQ_EN
            check("pulp_irq", pulp_irq, irq_exp);
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b1;
        // usb_write_flicker is already high at reset release: exactly one push of 0x11.
        reset_i            = 1'b1;
        flush_i            = 1'b0;
        usb_wdata          = 8'h11;
        pulp_wdata         = 8'h00;
        usb_write_flicker  = 1'b1;
        usb_read_flicker   = 1'b0;
        pulp_write_flicker = 1'b0;
        pulp_read_flicker  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pulp_status", pulp_status, 0);
        check("reset_usb_status", usb_status, 0);
        check("reset_pulp_rdata", pulp_rdata, 0);
        check("reset_usb_rdata", usb_rdata, 0);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check("release_event_count", pulp_status, 5'h01);
        check("release_event_data", pulp_rdata, 8'h11);
        step(0, 0, 0, 0, 8'h11, 8'h00, 0);
        #1;
        check("release_no_repeat", pulp_status, 5'h01);
        do_flush();

        // Three USB pushes, then a PULPino pop.
        step(1, 0, 0, 0, 8'h11, 8'h00, 0);
        step(1, 0, 0, 0, 8'h22, 8'h00, 0);
        step(1, 0, 0, 0, 8'h33, 8'h00, 0);
        #1;
        check("u2p_count3", pulp_status, 5'h03);
        check("u2p_head_11", pulp_rdata, 8'h11);
        step(0, 0, 0, 1, 8'h33, 8'h00, 0);
        #1;
        check("u2p_head_22", pulp_rdata, 8'h22);
        check("u2p_count2", pulp_status, 5'h02);
        do_flush();

        // Five PULPino pushes into a 4-deep FIFO, then drain in order.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00, 8'(8'hA0 + i), 0);
        #1;
        check("p2u_full_ovf", usb_status, 5'h14);
        for (int i = 0; i < 4; i++) begin
            check("p2u_drain", usb_rdata, 8'(8'hA0 + i));
            step(0, 1, 0, 0, 8'h00, 8'h00, 0);
            #1;
        end
        check("p2u_drained_status", usb_status, 5'h10);
        check("p2u_drained_rdata", usb_rdata, 8'h00);
        do_flush();

        // Pop on empty P2U.
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        #1;
        check("p2u_underflow", pulp_status, 5'h08);
        check("p2u_empty_status", usb_status, 5'h00);
        check("p2u_empty_rdata", usb_rdata, 8'h00);
        do_flush();

        // Full U2P: simultaneous push+pop keeps count, no overflow, 0x55 lands last.
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 8'(i), 8'h00, 0);
        step(1, 0, 0, 1, 8'h55, 8'h00, 0);
        #1;
        check("full_pushpop_status", pulp_status, 5'h04);
        check("full_pushpop_head", pulp_rdata, 8'h02);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00, 8'h00, 0);
        #1;
        check("full_pushpop_last", pulp_rdata, 8'h55);
        check("full_pushpop_cnt1", pulp_status, 5'h01);
        do_flush();

        // Push while full is dropped, sets overflow, raises no interrupt.
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 8'(8'h40 + i), 8'h00, 0);
        step(1, 0, 0, 0, 8'h99, 8'h00, 0);
        #1;
        check("u2p_overflow", pulp_status, 5'h14);
        check("u2p_overflow_head", pulp_rdata, 8'h41);
`ifdef USB_PULPINO_MAILBOX_IRQ_EN
        check("irq_dropped_push", pulp_irq, 1'b0);
`endif
        do_flush();

        // Empty U2P: push accepted, pop ignored, underflow set.
        step(1, 0, 0, 1, 8'h66, 8'h00, 0);
        #1;
        check("empty_pushpop_pulp", pulp_status, 5'h01);
        check("empty_pushpop_usb", usb_status, 5'h08);
        check("empty_pushpop_data", pulp_rdata, 8'h66);
`ifdef USB_PULPINO_MAILBOX_IRQ_EN
        check("irq_accepted_push", pulp_irq, 1'b1);
`endif

        // Flush wins over concurrent pushes on both sides, with no replay afterwards.
        step(1, 0, 1, 0, 8'h77, 8'h88, 1);
        #1;
        check("flush_pulp_status", pulp_status, 5'h00);
        check("flush_usb_status", usb_status, 5'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 8'h00, 8'h00, 0);
            #1;
            check("post_flush_pulp", pulp_status, 5'h00);
            check("post_flush_usb", usb_status, 5'h00);
        end

        // Randomized traffic with varying push pressure to exercise full/empty boundaries.
        for (int i = 0; i < 600; i++) begin
            int push_pct;
            push_pct = (i / 100) % 3 == 0 ? 30 : ((i / 100) % 3 == 1 ? 50 : 75);
            step($urandom_range(0, 99) < push_pct,
                 $urandom_range(0, 99) < (100 - push_pct),
                 $urandom_range(0, 99) < push_pct,
                 $urandom_range(0, 99) < (100 - push_pct),
                 8'($urandom), 8'($urandom),
                 $urandom_range(0, 47) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
